// File: rtl/double_exp_mod_if.sv
// double_exp_mod host handshake: carry-save operand in,
// carry-save result, busy flag and done pulse out.
interface double_exp_mod_if #(
  parameter int W = 8
);
  logic         ld;
  logic [W-1:0] xs;
  logic [W-1:0] xc;
  logic         busy;
  logic         dn;
  logic [W-1:0] ys;
  logic [W-1:0] yc;

  modport master (
    output ld, xs, xc,
    input  busy, dn, ys, yc
  );

  modport slave (
    input  ld, xs, xc,
    output busy, dn, ys, yc
  );
endinterface

// File: rtl/double_exp_mod.sv
// Repeated modular squaring: y = x^(2^K) mod N, carry-save in/out.
// DOUBLE_EXP_MOD_RESTART_EN: ld while busy restarts the job.
module double_exp_mod #(
  parameter int          W = 8,
  parameter int unsigned N = 221,
  parameter int unsigned K = 1000
) (
  input logic           clk,
  input logic           rst_n,
  double_exp_mod_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    SQUARE
  } state_t;

  localparam int JW = $clog2(W + 1);
  localparam int IW = $clog2(W);

  typedef logic [2*W:0] ext_t;
  typedef logic [W+1:0] acc_t;

  localparam ext_t NE = ext_t'(N);
  localparam acc_t NA = acc_t'(N);

`ifdef DOUBLE_EXP_MOD_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [W:0]    x_q, x_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [JW-1:0] j_q, j_d;
  logic [IW-1:0] i_q, i_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [W-1:0]  ys_q, ys_d;
  logic          dn_q, dn_d;
  logic          busy_q, busy_d;

  ext_t         xe, nsh, xr;
  acc_t         a1, a2, a3;
  logic [W-1:0] xw;
  logic         unused_bits;

  assign xw  = x_q[W-1:0];
  assign xe  = ext_t'(x_q);
  assign nsh = NE << j_q;
  assign xr  = (xe >= nsh) ? xe - nsh : xe;

  // 2*acc + bit*x < 3N, so two trial subtractions bring it below N
  assign a1 = acc_t'({acc_q, 1'b0})
            + (xw[i_q] ? acc_t'(xw) : '0);
  assign a2 = (a1 >= NA) ? a1 - NA : a1;
  assign a3 = (a2 >= NA) ? a2 - NA : a2;

  assign unused_bits = ^{xr[2*W:W+1], a3[W+1:W]};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    j_d     = j_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    ys_d    = ys_q;
    dn_d    = 1'b0;
    busy_d  = busy_q;
    if (bus.ld && (state_q == IDLE || RESTART)) begin
      x_d     = {1'b0, bus.xs} + {1'b0, bus.xc};
      acc_d   = '0;
      j_d     = JW'(W);
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = REDUCE;
    end else begin
      unique case (state_q)
        IDLE: ;
        REDUCE: begin
          x_d = xr[W:0];
          if (j_q != '0) begin
            j_d = j_q - 1'b1;
          end else if (K == 0) begin
            ys_d    = xr[W-1:0];
            dn_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            acc_d   = '0;
            i_d     = IW'(W - 1);
            state_d = SQUARE;
          end
        end
        SQUARE: begin
          acc_d = a3[W-1:0];
          if (i_q != '0) begin
            i_d = i_q - 1'b1;
          end else begin
            x_d   = {1'b0, a3[W-1:0]};
            acc_d = '0;
            i_d   = IW'(W - 1);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == 32'(K - 1)) begin
              ys_d    = a3[W-1:0];
              dn_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      j_q     <= '0;
      i_q     <= '0;
      cnt_q   <= '0;
      ys_q    <= '0;
      dn_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      j_q     <= j_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      ys_q    <= ys_d;
      dn_q    <= dn_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.dn   = dn_q;
  assign bus.ys   = ys_q;
  assign bus.yc   = '0;
endmodule

// File: tb/tb_double_exp_mod.sv
// Bench for double_exp_mod: four instances (K=0,1,2,1000)
// checked against an arithmetic model of x^(2^K) mod N.
module tb_double_exp_mod;
  localparam int          W  = 8;
  localparam int unsigned NM = 221;
  localparam int unsigned KV[4] = '{0, 1, 2, 1000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         ld[4];
  logic [W-1:0] xs[4];
  logic [W-1:0] xc[4];
  logic         busy[4];
  logic         dn[4];
  logic [W-1:0] ys[4];
  logic [W-1:0] yc[4];

  for (genvar g = 0; g < 4; g++) begin : u
    double_exp_mod_if #(.W(W)) bus ();
    assign bus.ld = ld[g];
    assign bus.xs = xs[g];
    assign bus.xc = xc[g];
    assign busy[g] = bus.busy;
    assign dn[g]   = bus.dn;
    assign ys[g]   = bus.ys;
    assign yc[g]   = bus.yc;
    double_exp_mod #(
      .W(W),
      .N(NM),
      .K(KV[g])
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
  end

  int tests = 0;
  int fails = 0;

  task automatic check(string tag, longint got, longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(int unsigned k, int a, int b);
    longint x = longint'(a + b) % longint'(NM);
    for (int unsigned i = 0; i < k; i++) x = (x * x) % longint'(NM);
    return x;
  endfunction

  function automatic int lat(int d);
    return (W + 1) + int'(KV[d]) * W;
  endfunction

  // called at a negedge; returns at the negedge after the ld edge
  task automatic go(int d, int a, int b);
    ld[d] = 1'b1;
    xs[d] = W'(a);
    xc[d] = W'(b);
    @(posedge clk);
    @(negedge clk);
    ld[d] = 1'b0;
    check("busy_up", longint'(busy[d]), 1);
    check("dn_low", longint'(dn[d]), 0);
  endtask

  task automatic wait_done(int d, int n0, int l, longint e, string tag);
    int n = n0;
    while (!dn[d] && n < l + 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_lat"}, longint'(n), longint'(l));
    check({tag, "_ys"}, longint'(ys[d]), e);
    check({tag, "_yc"}, longint'(yc[d]), 0);
    check({tag, "_busy"}, longint'(busy[d]), 0);
  endtask

  initial begin
    int seen;
    for (int d = 0; d < 4; d++) begin
      ld[d] = 1'b0;
      xs[d] = '0;
      xc[d] = '0;
    end
    #12;
    for (int d = 0; d < 4; d++) begin
      check("rst_busy", longint'(busy[d]), 0);
      check("rst_dn", longint'(dn[d]), 0);
      check("rst_ys", longint'(ys[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    go(0, 200, 100); wait_done(0, 0, 9, 79, "k0");
    go(1, 200, 100); wait_done(1, 0, 17, 53, "k1");
    go(2, 200, 100); wait_done(2, 0, 25, 157, "k2");
    go(0, 255, 255); wait_done(0, 0, 9, 68, "max");
    go(1, 220, 0);   wait_done(1, 0, 17, 1, "nm1");
    go(1, 0, 0);     wait_done(1, 0, 17, 0, "zero");

    for (int r = 0; r < 30; r++) begin
      int d = int'($urandom_range(0, 2));
      int a = int'($urandom_range(0, 255));
      int b = int'($urandom_range(0, 255));
      go(d, a, b);
      wait_done(d, 0, lat(d), model(KV[d], a, b), "rnd");
    end

    go(3, 1, 0);     wait_done(3, 0, lat(3), 1, "dflt");
    go(3, 200, 100); wait_done(3, 0, lat(3), model(1000, 200, 100), "dflt2");

    go(2, 200, 100);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy", longint'(busy[2]), 0);
    check("mid_dn", longint'(dn[2]), 0);
    check("mid_ys", longint'(ys[2]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (dn[2]) seen++;
    end
    check("no_dn", longint'(seen), 0);
    go(2, 78, 1); wait_done(2, 0, 25, 157, "postrst");

    go(2, 200, 100);
    repeat (4) @(negedge clk);
    ld[2] = 1'b1;
    xs[2] = W'(1);
    xc[2] = W'(0);
    @(negedge clk);
    ld[2] = 1'b0;
`ifdef DOUBLE_EXP_MOD_RESTART_EN
    wait_done(2, 5, 30, 1, "busyld");
`else
    wait_done(2, 5, 25, 157, "busyld");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/double_exp_mod.md
# double_exp_mod

Parametrised repeated modular squaring engine: computes y ≡ x^(2^K) mod N for a carry-save W-bit input and returns a carry-save result. It is the generalised successor of the fixed-modulus, fixed-count double-exponentiation circuits: modulus, width and squaring count are parameters, and it adds async reset, a busy flag and an optional restart-on-load mode. It sits behind a host that presents operands and waits for a done pulse.

## Interface
- W, 8: operand width; legal range 2..32.
- N, 221: modulus; 2 ≤ N < 2^W.
- K, 1000: number of squarings; 0 allowed; K < 2^32.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- ld  in  1  load strobe; sampled on rising clk.
- xs  in  W  input, sum half of carry-save operand.
- xc  in  W  input, carry half; x = xs + xc (W+1-bit true sum).
- busy  out  1  high while a computation is in progress.
- dn  out  1  one-cycle done pulse.
- ys  out  W  result, sum half.
- yc  out  W  result, carry half; always 0 from this block.

## Operation
- States: IDLE, REDUCE, SQUARE.
- IDLE: on edge with ld=1, register x = xs+xc (W+1 bits), set busy=1, go to REDUCE with j=W.
- REDUCE: restoring reduction, one step per cycle for j=W down to 0: if x ≥ N·2^j then x -= N·2^j. Compare at W+1+W bits; no truncation. After j=0, x < N.
- SQUARE: K squarings. Each squaring runs W cycles: acc=0; for bit i=W-1 down to 0 of x: acc = 2·acc + x[i]·x, then up to two conditional subtractions of N, keeping acc < N. Internal width W+2. After bit 0, x = acc, squaring counter increments.
- Completion, on the final REDUCE edge if K=0, else on the final SQUARE edge: ys<=x, yc<=0, dn<=1, busy<=0, go to IDLE.
- dn clears on the next edge. ys/yc hold until the next completion.
- ld while busy: ignored (see Configuration).
- ld on the cycle dn is high: accepted normally (state is IDLE).
- Arithmetic is exact for all xs, xc in [0, 2^W-1]. Result ys is canonical, in [0, N-1].

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, dn=0, ys=0, yc=0, all counters 0. Takes effect immediately and overrides clk.
- Reset mid-operation aborts the computation. No dn is produced; outputs read 0.
- Latency: ld is sampled at edge 0. dn and the new ys are visible after edge L = (W+1) + K·W. Defaults: L = 8009.
- busy rises after edge 0 and falls after edge L, together with the dn rise.
- Minimum issue interval: L+1 edges (ld on the dn cycle is accepted).
- xs/xc need to be valid only on the ld edge.

## Configuration
- DOUBLE_EXP_MOD_RESTART_EN undefined: ld while busy is ignored; the running computation completes unaffected.
- DOUBLE_EXP_MOD_RESTART_EN defined: ld while busy aborts the current computation and loads new xs/xc exactly as from IDLE. The next dn comes L edges after the restarting ld. No dn is produced for the aborted job, and ys/yc keep their previous value.

## Test plan
- W=8, N=221, K=0; ld with xs=200, xc=100 -> dn after edge 9; ys=79, yc=0; busy high edges 0..9.
- W=8, N=221, K=1; xs=200, xc=100 -> dn after edge 17, ys=53. With K=2 -> dn after edge 25, ys=157.
- Boundaries, K=1 unless noted:
  - xs=255, xc=255, K=0 -> ys=68.
  - xs=220, xc=0 -> ys=1.
  - xs=0, xc=0 -> ys=0.
- Defaults (K=1000): xs=1, xc=0 -> dn after edge 8009, ys=1, dn high exactly one cycle. A second ld on the dn cycle is accepted.
- K=2, xs=200, xc=100: pulse rst_n=0 at edge 10 -> busy, dn, ys drop to 0 immediately, no dn. Then ld with xs=78, xc=1 -> ys=157 after 25 edges.
- Busy-ld, K=2: ld xs=200, xc=100; at edge 5 ld xs=1, xc=0.
  - Without the macro: ys=157 at edge 25.
  - With DOUBLE_EXP_MOD_RESTART_EN: no dn at edge 25; ys=1 at edge 30.
